// File: rtl/model_seq_ctrl_if.sv
// rtl/model_seq_ctrl_if.sv - stream, weight-write and model handshake bundle for model_seq_ctrl
interface model_seq_ctrl_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] s_w_data;
    logic        s_w_valid;
    logic        s_w_ready;
    logic [15:0] s_px_data;
    logic        s_px_valid;
    logic        s_px_ready;
    logic        weight_wr_en;
    logic [31:0] weight_wr_addr;
    logic [15:0] weight_wr_data;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_valid;
    logic        fifo_almost_full;

    modport slave (
        input  start, s_w_data, s_w_valid, s_px_data, s_px_valid, o_valid, fifo_almost_full,
        output busy, done, error, s_w_ready, s_px_ready,
               weight_wr_en, weight_wr_addr, weight_wr_data, i_data, i_valid
    );

    modport master (
        output start, s_w_data, s_w_valid, s_px_data, s_px_valid, o_valid, fifo_almost_full,
        input  busy, done, error, s_w_ready, s_px_ready,
               weight_wr_en, weight_wr_addr, weight_wr_data, i_data, i_valid
    );
endinterface

// File: rtl/model_seq_ctrl.sv
// rtl/model_seq_ctrl.sv - weight load / settle / pixel stream / drain sequencer for one model pass
// Optional DRAIN watchdog enabled by defining MODEL_SEQ_CTRL_TIMEOUT_EN.
module model_seq_ctrl #(
    parameter int WEIGHT_COUNT   = 77,
    parameter int IMAGE_SIZE     = 25,
    parameter int OUT_COUNT      = 25,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    model_seq_ctrl_if.slave bus
);
    localparam int W_W     = $clog2(WEIGHT_COUNT + 1);
    localparam int P_W     = $clog2(IMAGE_SIZE + 1);
    localparam int O_W     = $clog2(OUT_COUNT + 1);
    // One timer serves both the settle interval and the drain watchdog.
    localparam int TMR_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SETTLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [W_W-1:0]   w_cnt;
    logic [P_W-1:0]   px_cnt;
    logic [O_W-1:0]   out_cnt;
    logic [TMR_W-1:0] tmr;
    logic             px_en;

    logic w_hs;
    logic px_hs;
    logic count_ov;

    // Almost-full gates pixel ready combinationally so a same-cycle rise blocks the handshake.
    assign bus.s_px_ready = px_en & ~bus.fifo_almost_full;
    assign w_hs           = bus.s_w_ready & bus.s_w_valid;
    assign px_hs          = bus.s_px_ready & bus.s_px_valid;
    assign count_ov       = bus.o_valid && (state == STREAM || state == DRAIN)
                            && (out_cnt != O_W'(OUT_COUNT));

`ifndef MODEL_SEQ_CTRL_TIMEOUT_EN
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            w_cnt              <= '0;
            px_cnt             <= '0;
            out_cnt            <= '0;
            tmr                <= '0;
            px_en              <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.s_w_ready      <= 1'b0;
            bus.weight_wr_en   <= 1'b0;
            bus.weight_wr_addr <= '0;
            bus.weight_wr_data <= '0;
            bus.i_valid        <= 1'b0;
            bus.i_data         <= '0;
`ifdef MODEL_SEQ_CTRL_TIMEOUT_EN
            bus.error          <= 1'b0;
`endif
        end else begin
            bus.weight_wr_en <= 1'b0;
            bus.i_valid      <= 1'b0;
            bus.done         <= 1'b0;
            if (count_ov) begin
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= LOAD_W;
                        bus.busy      <= 1'b1;
                        bus.s_w_ready <= 1'b1;
                        w_cnt         <= '0;
                        px_cnt        <= '0;
                        out_cnt       <= '0;
                        tmr           <= '0;
`ifdef MODEL_SEQ_CTRL_TIMEOUT_EN
                        bus.error     <= 1'b0;
`endif
                    end
                end
                LOAD_W: begin
                    if (w_hs) begin
                        bus.weight_wr_en   <= 1'b1;
                        bus.weight_wr_addr <= {{(32 - W_W){1'b0}}, w_cnt};
                        bus.weight_wr_data <= bus.s_w_data;
                        w_cnt              <= w_cnt + 1'b1;
                        if (w_cnt == W_W'(WEIGHT_COUNT - 1)) begin
                            state         <= SETTLE;
                            bus.s_w_ready <= 1'b0;
                            tmr           <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                        state <= STREAM;
                        px_en <= 1'b1;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                STREAM: begin
                    if (px_hs) begin
                        bus.i_valid <= 1'b1;
                        bus.i_data  <= bus.s_px_data;
                        px_cnt      <= px_cnt + 1'b1;
                        if (px_cnt == P_W'(IMAGE_SIZE - 1)) begin
                            state <= DRAIN;
                            px_en <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_cnt == O_W'(OUT_COUNT)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
`ifdef MODEL_SEQ_CTRL_TIMEOUT_EN
                    else if (bus.o_valid) begin
                        tmr <= '0;
                    end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= DONE;
                        bus.done  <= 1'b1;
                        bus.error <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
